// File: rtl/div.sv
// Iterative radix-2 restoring divider (DIV.W/DIV.WU/MOD.W/MOD.WU), one quotient bit per cycle.
// Optional macro DIV_FAST_EN: accept-cycle early-out for y==0 or |x|<|y|.
module div #(
  parameter int WIDTH = 32
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             div_signed,
  input  logic             use_rem,
  input  logic             div_cancel,
  output logic             div_ok,
  output logic [WIDTH-1:0] div_result,
  output logic [1:0]       div_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Handshake: an op is accepted on a rising edge where div_valid && div_ready
  // && !div_cancel; div_ok is a one-cycle pulse in DONE, masked by div_cancel.

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] x_q;
  logic             sgn_q_q;
  logic             sgn_r_q;
  logic             yz_q;
  logic             use_rem_q;
  logic             ok_q;
  logic [WIDTH-1:0] result_q;

  logic             x_neg;
  logic             y_neg;
  logic [WIDTH-1:0] ax;
  logic [WIDTH-1:0] ay;
  logic             y_zero;
  logic             fast_hit;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    x_neg  = div_signed & x[WIDTH-1];
    y_neg  = div_signed & y[WIDTH-1];
    ax     = x_neg ? (~x + 1'b1) : x;
    ay     = y_neg ? (~y + 1'b1) : y;
    y_zero = (y == '0);
`ifdef DIV_FAST_EN
    fast_hit = y_zero | (ax < ay);
`else
    fast_hit = 1'b0;
`endif
  end

  // The partial remainder is widened by one bit so divisors above 2^(WIDTH-1)
  // never lose the carried-out MSB of the shifted remainder.
  always_comb begin
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    qbit   = ~diff[WIDTH];
    rem_d  = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_d  = {dvd_q[WIDTH-2:0], qbit};
    q_fix  = yz_q ? '1  : (sgn_q_q ? (~quo_d + 1'b1) : quo_d);
    r_fix  = yz_q ? x_q : (sgn_r_q ? (~rem_d + 1'b1) : rem_d);
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      x_q       <= '0;
      sgn_q_q   <= 1'b0;
      sgn_r_q   <= 1'b0;
      yz_q      <= 1'b0;
      use_rem_q <= 1'b0;
      ok_q      <= 1'b0;
      result_q  <= '0;
    end else begin
      ok_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (div_valid && !div_cancel) begin
            dvd_q     <= ax;
            dvs_q     <= ay;
            rem_q     <= '0;
            x_q       <= x;
            sgn_q_q   <= x_neg ^ y_neg;
            sgn_r_q   <= x_neg;
            yz_q      <= y_zero;
            use_rem_q <= use_rem;
            cnt_q     <= CW'(WIDTH - 1);
            if (fast_hit) begin
              state_q  <= S_DONE;
              ok_q     <= 1'b1;
              result_q <= use_rem ? x : (y_zero ? '1 : '0);
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (div_cancel) begin
            state_q <= S_IDLE;
          end else begin
            dvd_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              state_q  <= S_DONE;
              ok_q     <= 1'b1;
              result_q <= use_rem_q ? r_fix : q_fix;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign div_ready  = (state_q == S_IDLE);
  assign div_ok     = ok_q & (state_q == S_DONE) & ~div_cancel;
  assign div_result = result_q;
  assign div_state  = state_q;

endmodule

// File: tb/tb_div.sv
// Directed bench for div: hand-computed quotient/remainder vectors, latency,
// cancel, asynchronous reset and back-to-back acceptance.
module tb_div;

  logic        div_clk = 1'b0;
  logic        resetn;
  logic        div_valid;
  logic        div_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        div_signed;
  logic        use_rem;
  logic        div_cancel;
  logic        div_ok;
  logic [31:0] div_result;
  logic [1:0]  div_state;

  int checks = 0;
  int errors = 0;
  int ok_cnt = 0;
  int cyc    = 0;
  logic [31:0] exp_q[$];

`ifdef DIV_FAST_EN
  localparam int FAST_LAT = 0;
`else
  localparam int FAST_LAT = 32;
`endif
  localparam int FULL_LAT = 32;

  div #(.WIDTH(32)) dut (
    .div_clk    (div_clk),
    .resetn     (resetn),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .x          (x),
    .y          (y),
    .div_signed (div_signed),
    .use_rem    (use_rem),
    .div_cancel (div_cancel),
    .div_ok     (div_ok),
    .div_result (div_result),
    .div_state  (div_state)
  );

  // clock / reset-independent monitors
  always #5 div_clk = ~div_clk;
  always @(posedge div_clk) cyc++;
  always @(negedge div_clk) if (div_ok) ok_cnt++;

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Latency is counted in clock edges from the accept edge to the first
  // cycle where div_ok is seen high.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic r, input logic [31:0] exp_res,
                        input int exp_lat);
    int k;
    logic [31:0] e;
    check({tag, "_ready"}, {31'd0, div_ready}, 32'd1);
    x = a; y = b; div_signed = s; use_rem = r; div_valid = 1'b1;
    exp_q.push_back(exp_res);
    tick();
    div_valid = 1'b0;
    x = $urandom; y = $urandom;
    div_signed = 1'($urandom_range(0, 1));
    use_rem    = 1'($urandom_range(0, 1));
    k = 0;
    while (!div_ok && k < 60) begin
      tick();
      k++;
    end
    check({tag, "_lat"}, k, exp_lat);
    e = exp_q.pop_front();
    check({tag, "_res"}, div_result, e);
    tick();
    check({tag, "_okpulse"}, {31'd0, div_ok}, 32'd0);
    check({tag, "_held"}, div_result, e);
  endtask

  initial begin
    int k;
    int t1;
    int saved_ok;
    resetn = 1'b0; div_valid = 1'b0; div_cancel = 1'b0;
    x = '0; y = '0; div_signed = 1'b0; use_rem = 1'b0;
    #12;
    check("rst_ready", {31'd0, div_ready}, 32'd1);
    check("rst_ok", {31'd0, div_ok}, 32'd0);
    check("rst_result", div_result, 32'd0);
    check("rst_state", {30'd0, div_state}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    run_op("u100_7_q", 32'd100, 32'd7, 1'b0, 1'b0, 32'h0000000E, FULL_LAT);
    run_op("u100_7_r", 32'd100, 32'd7, 1'b0, 1'b1, 32'h00000002, FULL_LAT);
    run_op("s_m7_2_q", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFD, FULL_LAT);
    run_op("s_m7_2_r", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 32'hFFFFFFFF, FULL_LAT);
    run_op("s_7_m2_q", 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, 32'hFFFFFFFD, FULL_LAT);
    run_op("s_7_m2_r", 32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 32'h00000001, FULL_LAT);
    run_op("s_ovf_q", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, FULL_LAT);
    run_op("s_ovf_r", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, FULL_LAT);
    run_op("u_ovf_q", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, FAST_LAT);
    run_op("u_ovf_r", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, FAST_LAT);
    run_op("u_5_0_q", 32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, FAST_LAT);
    run_op("u_5_0_r", 32'd5, 32'd0, 1'b0, 1'b1, 32'h00000005, FAST_LAT);
    run_op("s_5_0_q", 32'd5, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFF, FAST_LAT);
    run_op("s_5_0_r", 32'd5, 32'd0, 1'b1, 1'b1, 32'h00000005, FAST_LAT);
    run_op("s_m5_0_q", 32'hFFFFFFFB, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFF, FAST_LAT);
    run_op("s_m5_0_r", 32'hFFFFFFFB, 32'd0, 1'b1, 1'b1, 32'hFFFFFFFB, FAST_LAT);
    run_op("u_big_q", 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b0, 32'h00000001, FULL_LAT);
    run_op("u_big_r", 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b1, 32'h7FFFFFFE, FULL_LAT);

    // cancel has priority over a start request in IDLE
    div_valid = 1'b1; div_cancel = 1'b1; x = 32'd9; y = 32'd4;
    tick();
    check("idle_cancel_ready", {31'd0, div_ready}, 32'd1);
    div_valid = 1'b0; div_cancel = 1'b0;

    // cancel at step 10 of 1000/3
    saved_ok = ok_cnt;
    x = 32'd1000; y = 32'd3; div_signed = 1'b0; use_rem = 1'b0; div_valid = 1'b1;
    tick();
    div_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    div_cancel = 1'b1;
    tick();
    div_cancel = 1'b0;
    check("cancel_ready", {31'd0, div_ready}, 32'd1);
    check("cancel_result", div_result, 32'h7FFFFFFE);
    for (int i = 0; i < 40; i++) tick();
    check("cancel_no_ok", ok_cnt, saved_ok);
    run_op("after_cancel_q", 32'd9, 32'd4, 1'b0, 1'b0, 32'd2, FULL_LAT);
    run_op("after_cancel_r", 32'd9, 32'd4, 1'b0, 1'b1, 32'd1, FULL_LAT);

    // asynchronous reset between edges in the middle of CALC
    saved_ok = ok_cnt;
    x = 32'd1000; y = 32'd3; div_signed = 1'b0; use_rem = 1'b0; div_valid = 1'b1;
    tick();
    div_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 resetn = 1'b0;
    #1;
    check("arst_ready", {31'd0, div_ready}, 32'd1);
    check("arst_ok", {31'd0, div_ok}, 32'd0);
    check("arst_result", div_result, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("arst_rel_ready", {31'd0, div_ready}, 32'd1);
    check("arst_rel_result", div_result, 32'd0);
    for (int i = 0; i < 40; i++) tick();
    check("arst_no_ok", ok_cnt, saved_ok);

    // back-to-back with div_valid held high: completions 34 edges apart
    x = 32'd100; y = 32'd7; div_signed = 1'b0; use_rem = 1'b0; div_valid = 1'b1;
    k = 0;
    while (!div_ok && k < 60) begin tick(); k++; end
    check("b2b_first_lat", k, 33);
    check("b2b_first_res", div_result, 32'd14);
    t1 = cyc;
    tick();
    k = 0;
    while (!div_ok && k < 60) begin tick(); k++; end
    div_valid = 1'b0;
    check("b2b_spacing", cyc - t1, 34);
    check("b2b_second_res", div_result, 32'd14);
    tick();
    tick();
    check("b2b_idle", {31'd0, div_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
